// File: rtl/rx_fcs_check.sv
// rx_fcs_check: receive-path FCS checker.
// Runs reflected CRC-32 over each frame (destination MAC through FCS),
// forwards the frame minus its 4 FCS bytes through a 4-byte delay line,
// then reports CRC/length status once per frame and keeps wrapping
// good/bad frame counters.
module rx_fcs_check #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522,
   parameter int CNT_W   = 16
) (
   input  logic             rx_clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_en,
   output logic [7:0]       out_data,
   output logic             out_en,
   output logic             frame_done,
   output logic             frame_good,
   output logic             crc_err,
   output logic             len_err,
   output logic [10:0]      frame_len,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FRAME = 1'b1
   } state_t;

   localparam logic [31:0] C_CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] C_CRC_POLY = 32'hEDB8_8320;
   localparam logic [31:0] C_RESIDUE  = 32'hDEBB_20E3;
   localparam logic [10:0] C_LEN_SAT  = 11'd2047;
   localparam logic [10:0] C_MIN_LEN  = 11'(MIN_LEN);
   localparam logic [10:0] C_MAX_LEN  = 11'(MAX_LEN);

   // One byte of reflected CRC-32, LSB first, no final inversion.
   function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = (c >> 1) ^ C_CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   state_t           r_state;
   logic [31:0]      r_crc;
   logic [10:0]      r_len;
   logic [3:0][7:0]  r_dly;
   logic [3:0]       r_vld;

   logic             w_first;
   logic             w_end;
   logic             w_crc_err;
   logic             w_len_err;
   logic [31:0]      w_crc_seed;

   // Frame boundary detection and end-of-frame status, from current state.
   always_comb begin
      w_first    = in_en && (r_state == S_IDLE);
      w_end      = !in_en && (r_state == S_FRAME);
      w_crc_err  = (r_crc != C_RESIDUE);
      w_len_err  = (r_len < C_MIN_LEN) || (r_len > C_MAX_LEN);
      // A first byte restarts the CRC so back-to-back frames need no idle clear.
      if (w_first) begin
         w_crc_seed = C_CRC_INIT;
      end else begin
         w_crc_seed = r_crc;
      end
   end

   // Frame FSM, CRC/length accumulation, FCS-stripping delay line and status.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_crc      <= C_CRC_INIT;
         r_len      <= 11'd0;
         r_dly      <= '0;
         r_vld      <= 4'd0;
         out_data   <= 8'd0;
         out_en     <= 1'b0;
         frame_done <= 1'b0;
         frame_good <= 1'b0;
         crc_err    <= 1'b0;
         len_err    <= 1'b0;
         frame_len  <= 11'd0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         out_en     <= 1'b0;

         case (r_state)
            S_IDLE:  if (in_en)  r_state <= S_FRAME;
            S_FRAME: if (!in_en) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         if (in_en) begin
            r_crc <= f_crc_byte(w_crc_seed, in_data);
            if (w_first) begin
               r_len <= 11'd1;
            end else if (r_len != C_LEN_SAT) begin
               r_len <= r_len + 11'd1;
            end
            // A byte leaves stage 4 only when a newer byte pushes it out,
            // so the final 4 bytes (the FCS) never reach the output.
            r_dly    <= {r_dly[2:0], in_data};
            r_vld    <= {r_vld[2:0], 1'b1};
            out_en   <= r_vld[3];
            out_data <= r_dly[3];
         end else if (w_end) begin
            r_vld      <= 4'd0;
            frame_done <= 1'b1;
            crc_err    <= w_crc_err;
            len_err    <= w_len_err;
            frame_good <= !w_crc_err && !w_len_err;
            frame_len  <= r_len;
            if (!w_crc_err && !w_len_err) begin
               good_cnt <= good_cnt + 1'b1;
            end else begin
               bad_cnt <= bad_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_fcs_check.sv
// Directed bench for rx_fcs_check: builds frames with a reference FCS,
// drives them byte by byte and checks forwarded bytes and frame status.
module tb_rx_fcs_check;

   logic        rx_clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_en;
   logic [7:0]  out_data;
   logic        out_en;
   logic        frame_done;
   logic        frame_good;
   logic        crc_err;
   logic        len_err;
   logic [10:0] frame_len;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1522), .CNT_W(16)) dut (
      .rx_clk     (rx_clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_en      (in_en),
      .out_data   (out_data),
      .out_en     (out_en),
      .frame_done (frame_done),
      .frame_good (frame_good),
      .crc_err    (crc_err),
      .len_err    (len_err),
      .frame_len  (frame_len),
      .good_cnt   (good_cnt),
      .bad_cnt    (bad_cnt)
   );

   initial rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   typedef struct {
      logic        good;
      logic        ce;
      logic        le;
      logic [10:0] len;
      logic [15:0] gc;
      logic [15:0] bc;
   } snap_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] fr [0:2047];
   logic [7:0] oq [$];
   snap_t      sq [$];
   int         n_overlap = 0;
   int         n_wide = 0;
   logic       last_done = 1'b0;

   // Output monitor: collects forwarded bytes and status snapshots.
   always @(negedge rx_clk) begin
      snap_t s;
      if (out_en) oq.push_back(out_data);
      if (frame_done) begin
         s.good = frame_good;
         s.ce   = crc_err;
         s.le   = len_err;
         s.len  = frame_len;
         s.gc   = good_cnt;
         s.bc   = bad_cnt;
         sq.push_back(s);
      end
      if (out_en && frame_done) n_overlap++;
      if (frame_done && last_done) n_wide++;
      last_done = frame_done;
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'd0, d};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Fill n payload bytes with an incrementing pattern and append the FCS.
   task automatic build(input int n);
      logic [31:0] c;
      logic [31:0] fcs;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         fr[i] = 8'(i);
         c = crc_upd(c, fr[i]);
      end
      fcs = ~c;
      for (int k = 0; k < 4; k++) fr[n + k] = fcs[8*k +: 8];
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge rx_clk);
         in_en   = 1'b1;
         in_data = fr[i];
      end
      @(negedge rx_clk);
      in_en   = 1'b0;
      in_data = 8'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge rx_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare the forwarded stream against nf copies of fr[0..nb-1].
   task automatic chk_stream(input string tag, input int nf, input int nb);
      int mism;
      mism = 0;
      chk({tag, "_count"}, 32'(oq.size()), 32'(nf * nb));
      if (oq.size() == nf * nb) begin
         for (int i = 0; i < nf * nb; i++) if (oq[i] !== fr[i % nb]) mism++;
      end
      chk({tag, "_bytes"}, 32'(mism), 32'd0);
   endtask

   task automatic chk_snap(input string tag, input int idx, input logic good, input logic ce,
                           input logic le, input int len, input int gc, input int bc);
      chk({tag, "_done"}, 32'(sq.size() > idx), 32'd1);
      if (sq.size() > idx) begin
         chk({tag, "_good"}, 32'(sq[idx].good), 32'(good));
         chk({tag, "_crc_err"}, 32'(sq[idx].ce), 32'(ce));
         chk({tag, "_len_err"}, 32'(sq[idx].le), 32'(le));
         chk({tag, "_len"}, 32'(sq[idx].len), 32'(len));
         chk({tag, "_good_cnt"}, 32'(sq[idx].gc), 32'(gc));
         chk({tag, "_bad_cnt"}, 32'(sq[idx].bc), 32'(bc));
      end
   endtask

   task automatic do_reset;
      @(negedge rx_clk);
      rst = 1'b1;
      @(negedge rx_clk);
      rst = 1'b0;
      idle(1);
      oq.delete();
      sq.delete();
   endtask

   initial begin
      int oq_before;
      rst     = 1'b1;
      in_en   = 1'b0;
      in_data = 8'd0;
      idle(3);
      chk("rst_out_en", 32'(out_en), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_status", 32'({frame_good, crc_err, len_err}), 32'd0);
      chk("rst_len", 32'(frame_len), 32'd0);
      chk("rst_cnts", {good_cnt, bad_cnt}, 32'd0);
      rst = 1'b0;
      idle(2);
      oq.delete();
      sq.delete();

      // Valid 64-byte frame.
      build(60);
      send(64);
      idle(4);
      chk_stream("t1", 1, 60);
      chk("t1_ndone", 32'(sq.size()), 32'd1);
      chk_snap("t1", 0, 1'b1, 1'b0, 1'b0, 64, 1, 0);
      idle(5);
      chk("t1_hold_len", 32'(frame_len), 32'd64);
      chk("t1_hold_good", 32'(frame_good), 32'd1);

      // Same frame with bit 0 of byte 10 flipped.
      oq.delete();
      sq.delete();
      fr[10] = fr[10] ^ 8'h01;
      send(64);
      idle(4);
      chk_stream("t2", 1, 60);
      chk_snap("t2", 0, 1'b0, 1'b1, 1'b0, 64, 1, 1);

      // 60-byte frame with valid FCS: too short.
      oq.delete();
      sq.delete();
      build(56);
      send(60);
      idle(4);
      chk_stream("t3", 1, 56);
      chk_snap("t3", 0, 1'b0, 1'b0, 1'b1, 60, 1, 2);

      // Two valid frames separated by a single idle cycle.
      do_reset();
      build(60);
      send(64);
      send(64);
      idle(4);
      chk_stream("t4", 2, 60);
      chk("t4_ndone", 32'(sq.size()), 32'd2);
      chk_snap("t4a", 0, 1'b1, 1'b0, 1'b0, 64, 1, 0);
      chk_snap("t4b", 1, 1'b1, 1'b0, 1'b0, 64, 2, 0);

      // Reset at byte 30 of a frame, then a valid frame.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         @(negedge rx_clk);
         in_en   = 1'b1;
         in_data = fr[i];
      end
      @(negedge rx_clk);
      in_data = fr[30];
      rst     = 1'b1;
      @(negedge rx_clk);
      rst   = 1'b0;
      in_en = 1'b0;
      idle(4);
      chk("t5_no_done", 32'(sq.size()), 32'd0);
      chk("t5_cnts_clear", {good_cnt, bad_cnt}, 32'd0);
      oq.delete();
      send(64);
      idle(4);
      chk_stream("t5", 1, 60);
      chk_snap("t5", 0, 1'b1, 1'b0, 1'b0, 64, 1, 0);

      // Oversize frame with correct FCS, then a 3-byte runt.
      oq.delete();
      sq.delete();
      build(1526);
      send(1530);
      idle(4);
      chk_stream("t6", 1, 1526);
      chk_snap("t6a", 0, 1'b0, 1'b0, 1'b1, 1530, 1, 1);
      oq_before = oq.size();
      fr[0] = 8'hAA;
      fr[1] = 8'hBB;
      fr[2] = 8'hCC;
      send(3);
      idle(4);
      chk("t6_runt_no_out", 32'(oq.size()), 32'(oq_before));
      chk("t6_ndone", 32'(sq.size()), 32'd2);
      if (sq.size() > 1) begin
         chk("t6b_len_err", 32'(sq[1].le), 32'd1);
         chk("t6b_len", 32'(sq[1].len), 32'd3);
         chk("t6b_good", 32'(sq[1].good), 32'd0);
         chk("t6b_bad_cnt", 32'(sq[1].bc), 32'd2);
      end

      chk("overlap", 32'(n_overlap), 32'd0);
      chk("done_width", 32'(n_wide), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_fcs_check.md
Name: rx_fcs_check

Overview:
- Sits between the preamble/SFD stripper and the majority/log stages of the receive path.
- Runs CRC-32 over each received Ethernet frame, from the first destination-MAC byte through the last FCS byte.
- Forwards the frame with the 4 FCS bytes removed, then reports good/bad status and length once per frame.
- Keeps wrapping good/bad frame counters for the LED and log logic.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1522, maximum legal frame length in bytes, FCS included.
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- rx_clk  in  1  receive clock; all logic runs on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  frame byte, SFD already removed.
- in_en  in  1  high for every byte of a frame, contiguous; a low cycle ends the frame.
- out_data  out  8  frame byte with the FCS stripped.
- out_en  out  1  out_data valid.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_good  out  1  valid with frame_done: CRC correct and length legal.
- crc_err  out  1  valid with frame_done: CRC residue mismatch.
- len_err  out  1  valid with frame_done: length < MIN_LEN or > MAX_LEN.
- frame_len  out  11  valid with frame_done: byte count including FCS, saturating at 2047.
- good_cnt  out  CNT_W  frames with frame_good=1, wraps.
- bad_cnt  out  CNT_W  frames with frame_good=0, wraps.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0.
  - CRC register goes to 0xFFFFFFFF.
  - The delay line and its valid bits clear.
  - The FSM goes to IDLE.
  - A frame in progress is discarded with no frame_done.
- FSM has two states, IDLE and FRAME:
  - IDLE -> FRAME when in_en=1.
  - FRAME -> IDLE when in_en=0. frame_done fires on the cycle registered after this.
- CRC rules:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB first, byte-wide update.
  - The register is preloaded to 0xFFFFFFFF on the first byte, so back-to-back frames need no idle reset.
  - No final inversion.
  - The frame is CRC-correct when the register equals 0xDEBB20E3 after the last byte.
- Length:
  - An 11-bit counter increments on each in_en byte and saturates at 2047.
  - It reloads to 1 on the first byte of a frame.
- Delay line and out_en:
  - A 4-stage byte shift register with per-stage valid bits, advanced on in_en.
  - out_en=1 and out_data = the byte leaving stage 4, registered, only when a new in_en byte pushes a valid byte out.
  - Result: byte k appears 4 in_en cycles after it entered, delayed one further register stage.
  - The last 4 bytes of each frame (the FCS) are never output.
  - On frame end all valid bits clear.
- Short frames: a frame of 4 bytes or fewer produces no out_en. frame_done still fires with len_err=1.
- frame_done cycle:
  - frame_good = !crc_err && !len_err.
  - Exactly one of good_cnt or bad_cnt increments; both wrap at 2^CNT_W.
  - Status outputs hold their values until the next frame_done.
  - frame_done is high for exactly 1 cycle.
- Ordering: out_en never overlaps frame_done for the same frame; the last out_en precedes frame_done.
- Back-to-back frames (single idle cycle):
  - The next frame's first byte may arrive on the frame_done cycle.
  - The new CRC/length start must not corrupt the latched status of the finished frame.
- A frame longer than MAX_LEN is still forwarded in full, minus its FCS, and is flagged with len_err.

Test Plan:
- 64-byte frame (60 bytes 0x00..0x3B plus correct FCS) -> 60 out_en bytes identical to input; frame_done with frame_good=1, crc_err=0, len_err=0, frame_len=64; good_cnt=1.
- Same frame with bit 0 of byte 10 flipped -> 60 bytes forwarded; crc_err=1, frame_good=0; bad_cnt=1, good_cnt unchanged.
- 60-byte frame with valid FCS -> crc_err=0, len_err=1, frame_len=60; bad_cnt increments.
- Two 64-byte valid frames separated by one idle cycle -> two frame_done pulses, each frame_good=1; 120 total out_en bytes; good_cnt=2.
- rst asserted for 1 cycle at byte 30 of a frame, then a valid 64-byte frame -> no frame_done for the aborted frame; the second frame reports frame_good=1; counters show good=1, bad=0.
- 1530-byte frame with correct FCS, then a 3-byte frame -> first reports len_err=1, crc_err=0, frame_len=1530; second produces no out_en and reports len_err=1.
